// File: rtl/synapse_driver.sv
// Spike-to-current synapse driver: weighted accumulation into a saturating
// 16-bit current register with periodic exponential decay. Optional macro: SYN_SIGNED_WEIGHT_EN.
module synapse_driver #(
    parameter int N_IN         = 4,
    parameter int W_WIDTH      = 8,
    parameter int DECAY_SHIFT  = 3,
    parameter int DECAY_PERIOD = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN-1:0]         spike_in,
    input  logic                    wr_en,
    input  logic [$clog2(N_IN)-1:0] wr_addr,
    input  logic [W_WIDTH-1:0]      wr_data,
    output logic [15:0]             current_out,
    output logic                    current_valid,
    output logic                    busy,
    output logic                    spike_drop,
    output logic                    overflow
);

    localparam int AW = $clog2(N_IN);
    localparam int CW = $clog2(DECAY_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DECAY
    } state_t;

    state_t state;
    state_t state_next;

    logic [N_IN-1:0]    pending;
    logic [N_IN-1:0]    pending_next;
    logic [N_IN-1:0]    lowest_mask;
    logic [N_IN-1:0]    pending_clear;
    logic [N_IN-1:0]    drop_hits;
    logic [CW-1:0]      decay_cnt;
    logic               decay_req;
    logic               decay_req_next;
    logic               decay_wrap;
    logic [W_WIDTH-1:0] weights [N_IN];
    logic [W_WIDTH-1:0] sel_weight;
    logic [15:0]        current;
    logic [15:0]        current_next;
    logic [15:0]        current_decayed;
    logic [17:0]        weight_ext;
    logic [17:0]        sum;
    logic               sum_high;
    logic               sum_low;
    logic               clamp;

    // Scanning downward lets the lowest-index pending line overwrite the pick.
    always_comb begin
        lowest_mask = '0;
        sel_weight  = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lowest_mask    = '0;
                lowest_mask[i] = 1'b1;
                sel_weight     = weights[i];
            end
        end
    end

    always_comb begin
`ifdef SYN_SIGNED_WEIGHT_EN
        weight_ext = {{(18 - W_WIDTH){sel_weight[W_WIDTH-1]}}, sel_weight};
        sum        = {2'b00, current} + weight_ext;
        sum_low    = sum[17];
        sum_high   = !sum[17] && sum[16];
`else
        weight_ext = {{(18 - W_WIDTH){1'b0}}, sel_weight};
        sum        = {2'b00, current} + weight_ext;
        sum_low    = 1'b0;
        sum_high   = |sum[17:16];
`endif
    end

    assign current_decayed = current - (current >> DECAY_SHIFT);

    // One operation per cycle; an outstanding decay always beats a pending add.
    always_comb begin
        state_next    = IDLE;
        current_next  = current;
        pending_clear = '0;
        clamp         = 1'b0;
        if (decay_req) begin
            state_next   = DECAY;
            current_next = current_decayed;
        end else if (|pending) begin
            state_next    = ACCUM;
            pending_clear = lowest_mask;
            if (sum_high) begin
                current_next = 16'hFFFF;
                clamp        = 1'b1;
            end else if (sum_low) begin
                current_next = 16'h0000;
                clamp        = 1'b1;
            end else begin
                current_next = sum[15:0];
            end
        end
    end

    // A new strobe on a line being consumed this cycle stays pending and is not a drop.
    always_comb begin
        pending_next   = (pending & ~pending_clear) | spike_in;
        drop_hits      = spike_in & pending & ~pending_clear;
        decay_wrap     = (decay_cnt == CW'(DECAY_PERIOD - 1));
        decay_req_next = decay_wrap | (decay_req & (state_next != DECAY));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            current    <= '0;
            pending    <= '0;
            decay_cnt  <= '0;
            decay_req  <= 1'b0;
            busy       <= 1'b0;
            spike_drop <= 1'b0;
            overflow   <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                weights[i] <= W_WIDTH'(1);
            end
        end else begin
            state      <= state_next;
            current    <= current_next;
            pending    <= pending_next;
            decay_cnt  <= decay_wrap ? '0 : decay_cnt + CW'(1);
            decay_req  <= decay_req_next;
            busy       <= (|pending_next) | decay_req_next;
            spike_drop <= spike_drop | (|drop_hits);
            overflow   <= overflow | clamp;
            for (int i = 0; i < N_IN; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    weights[i] <= wr_data;
                end
            end
        end
    end

    assign current_out   = current;
    assign current_valid = (state != IDLE);

endmodule

// File: tb/tb_synapse_driver.sv
// Directed self-checking bench for synapse_driver; a second instance with a long
// decay period exercises the 65535 clamp without decay interference.
module tb_synapse_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  spike_in;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;

    logic [15:0] current_out;
    logic        current_valid;
    logic        busy;
    logic        spike_drop;
    logic        overflow;

    logic [15:0] sat_current;
    logic        sat_valid;
    logic        sat_busy;
    logic        sat_drop;
    logic        sat_overflow;

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    synapse_driver dut (
        .clk          (clk),
        .reset        (reset),
        .spike_in     (spike_in),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .current_out  (current_out),
        .current_valid(current_valid),
        .busy         (busy),
        .spike_drop   (spike_drop),
        .overflow     (overflow)
    );

    synapse_driver #(.DECAY_PERIOD(4096)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .spike_in     (spike_in),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .current_out  (sat_current),
        .current_valid(sat_valid),
        .busy         (sat_busy),
        .spike_drop   (sat_drop),
        .overflow     (sat_overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edges);
        end
    endtask

    // Inputs are held across exactly one rising edge, then outputs are sampled 1ns later.
    task automatic applyStimulus(input logic [3:0] spk, input logic we,
                                 input logic [1:0] addr, input logic [7:0] data);
        spike_in = spk;
        wr_en    = we;
        wr_addr  = addr;
        wr_data  = data;
        @(posedge clk);
        #1;
        edges++;
        spike_in = '0;
        wr_en    = 1'b0;
    endtask

    task automatic idle_cycle();
        applyStimulus(4'b0000, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_cycle();
        idle_cycle();
        reset = 1'b1;
        edges = 0;
    endtask

    initial begin
        int exp_cur;
        reset    = 1'b0;
        spike_in = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;

        // Reset values and an idle stretch with only decay pulses.
        do_reset();
        checkOutput("rst_current", current_out, 0);
        checkOutput("rst_valid", current_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_drop", spike_drop, 0);
        checkOutput("rst_overflow", overflow, 0);
        for (int k = 1; k <= 40; k++) begin
            idle_cycle();
            checkOutput("idle_current", current_out, 0);
            checkOutput("idle_valid", current_valid, (k == 17 || k == 33) ? 1 : 0);
            checkOutput("idle_busy", busy, (k == 16 || k == 32) ? 1 : 0);
        end
        checkOutput("idle_overflow", overflow, 0);
        checkOutput("idle_drop", spike_drop, 0);

        // Single weighted spike followed by one decay.
        do_reset();
        applyStimulus(4'b0000, 1'b1, 2'd2, 8'd100);
        applyStimulus(4'b0100, 1'b0, 2'd0, 8'd0);
        checkOutput("single_capture_cur", current_out, 0);
        checkOutput("single_capture_busy", busy, 1);
        idle_cycle();
        checkOutput("single_add_cur", current_out, 100);
        checkOutput("single_add_valid", current_valid, 1);
        idle_cycle();
        checkOutput("single_after_valid", current_valid, 0);
        repeat (12) idle_cycle();
        checkOutput("single_predecay_cur", current_out, 100);
        checkOutput("single_predecay_busy", busy, 1);
        idle_cycle();
        checkOutput("single_decay_cur", current_out, 88);
        checkOutput("single_decay_valid", current_valid, 1);

        // Four-line burst added in index order.
        do_reset();
        applyStimulus(4'b0000, 1'b1, 2'd0, 8'd10);
        applyStimulus(4'b0000, 1'b1, 2'd1, 8'd20);
        applyStimulus(4'b0000, 1'b1, 2'd2, 8'd30);
        applyStimulus(4'b0000, 1'b1, 2'd3, 8'd40);
        applyStimulus(4'b1111, 1'b0, 2'd0, 8'd0);
        checkOutput("burst_capture_busy", busy, 1);
        checkOutput("burst_capture_valid", current_valid, 0);
        idle_cycle();
        checkOutput("burst_add0", current_out, 10);
        checkOutput("burst_busy0", busy, 1);
        idle_cycle();
        checkOutput("burst_add1", current_out, 30);
        checkOutput("burst_busy1", busy, 1);
        idle_cycle();
        checkOutput("burst_add2", current_out, 60);
        checkOutput("burst_busy2", busy, 1);
        idle_cycle();
        checkOutput("burst_add3", current_out, 100);
        checkOutput("burst_valid3", current_valid, 1);
        checkOutput("burst_busy3", busy, 0);
        idle_cycle();
        checkOutput("burst_idle_valid", current_valid, 0);
        checkOutput("burst_idle_cur", current_out, 100);

        // Re-strobe while consumed keeps the bit pending; same-edge write reads old weight.
        applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
        applyStimulus(4'b0001, 1'b1, 2'd0, 8'd77);
        checkOutput("oldw_cur", current_out, 110);
        checkOutput("oldw_drop", spike_drop, 0);
        checkOutput("oldw_busy", busy, 1);
        idle_cycle();
        checkOutput("neww_cur", current_out, 187);
        checkOutput("neww_busy", busy, 0);
        idle_cycle();
        idle_cycle();

        // Two strobes on line 0 straddling a due decay: decay first, second strobe drops.
        applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
        checkOutput("drop_wrap_cur", current_out, 187);
        checkOutput("drop_wrap_valid", current_valid, 0);
        checkOutput("drop_wrap_busy", busy, 1);
        applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
        checkOutput("drop_decay_cur", current_out, 164);
        checkOutput("drop_decay_valid", current_valid, 1);
        checkOutput("drop_flag", spike_drop, 1);
        idle_cycle();
        checkOutput("drop_add_cur", current_out, 241);
        checkOutput("drop_add_busy", busy, 0);
        idle_cycle();
        checkOutput("drop_merged_cur", current_out, 241);
        checkOutput("drop_sticky", spike_drop, 1);

        // Saturation on the long-period instance: 257 * 255 = 65535 exactly.
        do_reset();
        applyStimulus(4'b0000, 1'b1, 2'd0, 8'd255);
        for (int n = 1; n <= 300; n++) begin
            applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
            idle_cycle();
            exp_cur = (n * 255 > 65535) ? 65535 : n * 255;
            checkOutput("sat_current", sat_current, exp_cur);
            checkOutput("sat_overflow", sat_overflow, (n * 255 > 65535) ? 1 : 0);
        end

        // Reset in the middle of a burst discards pending work and sticky flags.
        applyStimulus(4'b1111, 1'b0, 2'd0, 8'd0);
        applyStimulus(4'b1000, 1'b0, 2'd0, 8'd0);
        checkOutput("mid_drop_set", spike_drop, 1);
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_sat_ovf_sticky", sat_overflow, 1);
        reset = 1'b0;
        idle_cycle();
        checkOutput("mid_rst_cur", current_out, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_drop", spike_drop, 0);
        checkOutput("mid_rst_ovf", overflow, 0);
        checkOutput("mid_rst_sat_cur", sat_current, 0);
        checkOutput("mid_rst_sat_ovf", sat_overflow, 0);
        checkOutput("mid_rst_sat_drop", sat_drop, 0);
        checkOutput("mid_rst_sat_busy", sat_busy, 0);
        reset = 1'b1;
        edges = 0;
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            checkOutput("post_rst_cur", current_out, 0);
            checkOutput("post_rst_valid", current_valid, 0);
            checkOutput("post_rst_sat_valid", sat_valid, 0);
            checkOutput("post_rst_busy", busy, 0);
        end

`ifdef SYN_SIGNED_WEIGHT_EN
        // Inhibitory weight drives the current below zero and clamps.
        do_reset();
        applyStimulus(4'b0000, 1'b1, 2'd0, 8'd30);
        applyStimulus(4'b0000, 1'b1, 2'd1, 8'hCE);
        applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
        idle_cycle();
        checkOutput("signed_base_cur", current_out, 30);
        checkOutput("signed_base_ovf", overflow, 0);
        applyStimulus(4'b0010, 1'b0, 2'd0, 8'd0);
        idle_cycle();
        checkOutput("signed_clamp_cur", current_out, 0);
        checkOutput("signed_clamp_ovf", overflow, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
